// File: rtl/rtc_rd_seq_pkg.sv
// Shared definitions for the RTC bus sequencers: state encoding, bus idle
// value, RTC register map and a BCD sanity helper.
package rtc_rd_seq_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_A_AD,
    S_A_CS,
    S_A_WR,
    S_A_DRV,
    S_A_HOLD,
    S_A_WRH,
    S_A_CSH,
    S_A_ADH,
    S_A_REL,
    S_GAP,
    S_D_CS,
    S_D_RD,
    S_D_WAIT,
    S_D_SMP,
    S_D_RDH,
    S_D_CSH,
    S_NEXT
  } state_t;

  localparam logic [7:0] BUS_IDLE = 8'hFF;

  // RTC register map, shared with the write sequencer
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_SEC  = 8'h21;
  localparam logic [7:0] REG_MIN  = 8'h22;
  localparam logic [7:0] REG_HOUR = 8'h23;

  // Width of the phase-duration timer
  localparam int unsigned TMR_W = 8;

  // True when either nibble is not a decimal digit
  function automatic logic bcd_invalid(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/rtc_rd_seq_bus_timer.sv
// rtc_bus_timer: loadable down-counter with terminal-count flag. Loaded with
// N-1 on the cycle before a timed phase; o_tc marks the last cycle of it.
module rtc_bus_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down while enabled, holding at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/rtc_rd_seq.sv
// rtc_rd_seq: read-burst sequencer for the RTC multiplexed AD bus. Reads
// NUM_REGS consecutive registers from addr_base and strobes each byte out.
// Optional build macro RTC_RD_BCD_CHECK_EN adds the sticky bcd_err output.
module rtc_rd_seq
  import rtc_rd_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 3,
  parameter int unsigned PULSE_CYC = 5,
  parameter int unsigned GAP_CYC   = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr_base,
  input  logic [7:0] ad_in,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       busy,
  output logic       data_valid,
  output logic [2:0] data_idx,
  output logic [7:0] data_out,
  output logic       done
`ifdef RTC_RD_BCD_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_REGS - 1);

  state_t           r_state;
  logic [7:0]       r_addr;
  logic [2:0]       r_idx;
  logic             r_ad;
  logic             r_cs;
  logic             r_wr;
  logic             r_rd;
  logic [7:0]       r_ad_out;
  logic             r_ad_oe;
  logic             r_busy;
  logic             r_dv;
  logic [2:0]       r_data_idx;
  logic [7:0]       r_data_out;
  logic             r_done;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_tc;

  // Arm the timer on the cycle before each timed phase; count only inside it
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_en   = 1'b0;
    case (r_state)
      S_A_DRV: begin w_tmr_load = 1'b1; w_tmr_val = PULSE_LD; end
      S_A_REL: begin w_tmr_load = 1'b1; w_tmr_val = GAP_LD;   end
      S_D_RD:  begin w_tmr_load = 1'b1; w_tmr_val = PULSE_LD; end
      S_A_HOLD, S_GAP, S_D_WAIT: w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  rtc_bus_timer #(
    .W(TMR_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_value(w_tmr_val),
    .i_en   (w_tmr_en),
    .o_tc   (w_tmr_tc)
  );

`ifdef RTC_RD_BCD_CHECK_EN
  logic r_bcd_err;
`endif

  // Burst FSM: each transition sets the strobe levels of the state it enters,
  // so every output is registered and changes exactly one step per state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_idx      <= '0;
      r_ad       <= 1'b1;
      r_cs       <= 1'b1;
      r_wr       <= 1'b1;
      r_rd       <= 1'b1;
      r_ad_out   <= BUS_IDLE;
      r_ad_oe    <= 1'b0;
      r_busy     <= 1'b0;
      r_dv       <= 1'b0;
      r_data_idx <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
`ifdef RTC_RD_BCD_CHECK_EN
      r_bcd_err  <= 1'b0;
`endif
    end else begin
      r_dv   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_done high means this is the cycle right after a burst ended
          if (start && !r_done) begin
            r_addr  <= addr_base;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_ad    <= 1'b0;
            r_state <= S_A_AD;
`ifdef RTC_RD_BCD_CHECK_EN
            r_bcd_err <= 1'b0;
`endif
          end
        end
        S_A_AD:  begin r_cs <= 1'b0; r_state <= S_A_CS; end
        S_A_CS:  begin r_wr <= 1'b0; r_state <= S_A_WR; end
        S_A_WR: begin
          r_ad_out <= r_addr;
          r_ad_oe  <= 1'b1;
          r_state  <= S_A_DRV;
        end
        S_A_DRV: r_state <= S_A_HOLD;
        S_A_HOLD: begin
          if (w_tmr_tc) begin
            r_wr    <= 1'b1;
            r_state <= S_A_WRH;
          end
        end
        S_A_WRH: begin r_cs <= 1'b1; r_state <= S_A_CSH; end
        S_A_CSH: begin r_ad <= 1'b1; r_state <= S_A_ADH; end
        S_A_ADH: begin
          r_ad_out <= BUS_IDLE;
          r_ad_oe  <= 1'b0;
          r_state  <= S_A_REL;
        end
        S_A_REL: r_state <= S_GAP;
        S_GAP: begin
          if (w_tmr_tc) begin
            r_cs    <= 1'b0;
            r_state <= S_D_CS;
          end
        end
        S_D_CS: begin r_rd <= 1'b0; r_state <= S_D_RD; end
        S_D_RD: r_state <= S_D_WAIT;
        S_D_WAIT: begin
          if (w_tmr_tc) begin
            r_data_out <= ad_in;
            r_data_idx <= r_idx;
            r_dv       <= 1'b1;
`ifdef RTC_RD_BCD_CHECK_EN
            r_bcd_err  <= r_bcd_err | bcd_invalid(ad_in);
`endif
            r_state    <= S_D_SMP;
          end
        end
        S_D_SMP: begin r_rd <= 1'b1; r_state <= S_D_RDH; end
        S_D_RDH: begin r_cs <= 1'b1; r_state <= S_D_CSH; end
        S_D_CSH: r_state <= S_NEXT;
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_addr  <= r_addr + 8'd1;
            r_ad    <= 1'b0;
            r_state <= S_A_AD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ad         = r_ad;
  assign cs         = r_cs;
  assign wr         = r_wr;
  assign rd         = r_rd;
  assign ad_out     = r_ad_out;
  assign ad_oe      = r_ad_oe;
  assign busy       = r_busy;
  assign data_valid = r_dv;
  assign data_idx   = r_data_idx;
  assign data_out   = r_data_out;
  assign done       = r_done;
`ifdef RTC_RD_BCD_CHECK_EN
  assign bcd_err    = r_bcd_err;
`endif

endmodule
